// File: rtl/cevero_mem_pkg.sv
// Shared types and constants for the cevero data responder.
//   resp_entry_t     : one queued response {rdata, err, countdown}
//   MBOX_FLAG_WORD   : word index whose bit 0 drives done_o
//   MBOX_RESULT_WORD : word index mirrored on result_o
//   be_merge()       : byte-enable merge of a write into an existing word
package cevero_mem_pkg;

  // Countdown width bounds RVALID_LAT to 256.
  localparam int CNT_W            = 8;
  localparam int MBOX_FLAG_WORD   = 0;
  localparam int MBOX_RESULT_WORD = 1;

  typedef struct packed {
    logic [31:0]      rdata;
    logic             err;
    logic [CNT_W-1:0] countdown;
  } resp_entry_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    return w;
  endfunction

endpackage

// File: rtl/cevero_resp_fifo.sv
// In-order response queue with per-entry latency countdown.
// Entries are kept in a shift structure with the head at index 0; every
// stored countdown decrements (saturating at 0) each cycle.
//   clk, rst_n    : clock, async active-low reset (clears all entries)
//   push_i        : enqueue push_entry_i (caller guarantees not full)
//   push_entry_i  : entry to enqueue
//   pop_i         : dequeue the head (caller guarantees not empty)
//   head_o        : current head entry
//   count_o       : number of valid entries
module cevero_resp_fifo
  import cevero_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  resp_entry_t                  push_entry_i,
  input  logic                         pop_i,
  output resp_entry_t                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  resp_entry_t   entries_q [DEPTH];
  resp_entry_t   entries_d [DEPTH];
  resp_entry_t   aged      [DEPTH];
  logic [CW-1:0] count_q, count_d, base;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      aged[i] = entries_q[i];
      if (aged[i].countdown != '0) aged[i].countdown = aged[i].countdown - CNT_W'(1);
    end
  end

  // The new entry lands behind whatever survives this cycle's pop, so it is
  // never aged on the edge it is written.
  always_comb begin
    entries_d = aged;
    base      = count_q;
    if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = aged[i+1];
      entries_d[DEPTH-1] = '0;
      base = count_q - CW'(1);
    end
    for (int i = 0; i < DEPTH; i++)
      if (push_i && (CW'(i) == base)) entries_d[i] = push_entry_i;
    count_d = base + (push_i ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head_o  = entries_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/cevero_data_responder.sv
// Memory-side responder for a req/gnt/rvalid data port: word RAM with
// programmable grant wait states, fixed read latency, an in-order response
// queue and a done/result mailbox taken from words 0 and 1.
// Optional feature macro: CEVERO_RESP_ERR_EN -- word indices >= NUM_WORDS
// return an error response and write nothing; otherwise indices wrap.
//   clk, rst_n                 : clock, async active-low reset
//   req_i/gnt_o                : request / combinational grant
//   addr_i, we_i, be_i, wdata_i: byte address, write, byte enables, data
//   rvalid_o, rdata_o, err_o   : in-order response (data/err 0 when idle)
//   done_o, result_o           : mailbox flag and mirror of word 1
module cevero_data_responder
  import cevero_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_WORDS   = 256,
  parameter int GNT_WAIT    = 0,
  parameter int RVALID_LAT  = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int IDX_W  = $clog2(NUM_WORDS);
  localparam int WAIT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int QC_W   = $clog2(OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [ADDR_WIDTH-3:0] widx_full;
  logic [IDX_W-1:0]      widx;
  logic                  oob;
  logic                  wr_en;
  logic                  unused_addr;

  assign widx_full   = addr_i[ADDR_WIDTH-1:2];
  assign widx        = widx_full[IDX_W-1:0];
  assign unused_addr = ^{addr_i[1:0], widx_full};

`ifdef CEVERO_RESP_ERR_EN
  assign oob = |(widx_full >> IDX_W);
`else
  assign oob = 1'b0;
`endif

  // ---------------- wait counter and grant ----------------
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [QC_W-1:0]   q_count;

  assign gnt_o = req_i && (wait_q == WAIT_W'(GNT_WAIT)) && (q_count < QC_W'(OUTSTANDING));

  // Saturates at GNT_WAIT so a request stalled by a full queue is granted
  // as soon as a slot opens rather than wrapping past the match value.
  always_comb begin
    wait_d = wait_q;
    if (!req_i || gnt_o)                      wait_d = '0;
    else if (wait_q != WAIT_W'(GNT_WAIT))     wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // ---------------- RAM (not reset) ----------------
  assign wr_en = gnt_o && we_i && !oob;

  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= be_merge(mem[widx], wdata_i, be_i);
  end

  // ---------------- mailbox ----------------
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (wr_en) begin
      if (widx == IDX_W'(MBOX_FLAG_WORD) && be_i[0]) done_q   <= wdata_i[0];
      if (widx == IDX_W'(MBOX_RESULT_WORD))          result_q <= be_merge(mem[widx], wdata_i, be_i);
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

  // ---------------- response queue ----------------
  resp_entry_t push_entry, head;

  always_comb begin
    push_entry           = '0;
    push_entry.rdata     = (we_i || oob) ? '0 : mem[widx];
    push_entry.err       = oob;
    push_entry.countdown = CNT_W'(RVALID_LAT - 1);
  end

  cevero_resp_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (gnt_o),
    .push_entry_i (push_entry),
    .pop_i        (rvalid_o),
    .head_o       (head),
    .count_o      (q_count)
  );

  assign rvalid_o = (q_count != '0) && (head.countdown == '0);
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o && head.err;

endmodule

// File: tb/tb_cevero_data_responder.sv
module tb_cevero_data_responder;
  localparam int N  = 3;
  localparam int NW = 256;
  // Instance 0: GW0/LAT1, 1: GW3/LAT1, 2: GW0/LAT4; all OUTSTANDING=2
  localparam int GW_T  [N] = '{0, 3, 0};
  localparam int LAT_T [N] = '{1, 1, 4};
  localparam int OUT_T [N] = '{2, 2, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req [N]; logic gnt [N]; logic [31:0] addr [N]; logic we [N];
  logic [3:0] be [N]; logic [31:0] wdata [N];
  logic rvalid [N]; logic [31:0] rdata [N]; logic err [N];
  logic done [N]; logic [31:0] result [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    cevero_data_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW),
      .GNT_WAIT(GW_T[g]), .RVALID_LAT(LAT_T[g]), .OUTSTANDING(OUT_T[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req[g]), .gnt_o(gnt[g]),
      .addr_i(addr[g]), .we_i(we[g]), .be_i(be[g]), .wdata_i(wdata[g]),
      .rvalid_o(rvalid[g]), .rdata_o(rdata[g]), .err_o(err[g]),
      .done_o(done[g]), .result_o(result[g])
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] mmem [N][NW];
  bit          mdone [N];
  logic [31:0] mres [N];
  int          held [N];
  logic [31:0] qd [N][8]; bit qe [N][8]; int qdue [N][8];
  int          qh [N], qn [N];
  int          cyc;
  bit          exp_gnt [N], exp_rv [N];
  int          n_checks = 0, n_fail = 0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mdone[k] = 0; mres[k] = 0; held[k] = 0; qh[k] = 0; qn[k] = 0;
      exp_gnt[k] = 0; exp_rv[k] = 0;
    end
  endtask

  // Negedge: derive expectations for this cycle and compare every output.
  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      logic [31:0] erd; bit eerr;
      exp_gnt[k] = rst_n && req[k] && held[k] >= GW_T[k] && qn[k] < OUT_T[k];
      exp_rv[k]  = rst_n && qn[k] > 0 && qdue[k][qh[k]] <= cyc;
      erd  = exp_rv[k] ? qd[k][qh[k]] : 32'h0;
      eerr = exp_rv[k] ? qe[k][qh[k]] : 1'b0;
      n_checks += 6;
      if (gnt[k] !== exp_gnt[k]) begin n_fail++; $display("FAIL gnt[%0d] cyc %0d: got %b want %b", k, cyc, gnt[k], exp_gnt[k]); end
      if (rvalid[k] !== exp_rv[k]) begin n_fail++; $display("FAIL rvalid[%0d] cyc %0d: got %b want %b", k, cyc, rvalid[k], exp_rv[k]); end
      if (rdata[k] !== erd) begin n_fail++; $display("FAIL rdata[%0d] cyc %0d: got %h want %h", k, cyc, rdata[k], erd); end
      if (err[k] !== eerr) begin n_fail++; $display("FAIL err[%0d] cyc %0d: got %b want %b", k, cyc, err[k], eerr); end
      if (done[k] !== mdone[k]) begin n_fail++; $display("FAIL done[%0d] cyc %0d: got %b want %b", k, cyc, done[k], mdone[k]); end
      if (result[k] !== mres[k]) begin n_fail++; $display("FAIL result[%0d] cyc %0d: got %h want %h", k, cyc, result[k], mres[k]); end
    end
  endtask

  // Posedge: apply the accesses decided at the preceding negedge.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        int unsigned wfull; int idx, slot; bit oob; logic [31:0] word;
        if (exp_rv[k]) begin qh[k] = (qh[k] + 1) % 8; qn[k]--; end
        if (exp_gnt[k]) begin
          wfull = addr[k] >> 2;
`ifdef CEVERO_RESP_ERR_EN
          oob = wfull >= NW;
`else
          oob = 0;
`endif
          idx  = wfull % NW;
          word = 0;
          if (!we[k] && !oob) word = mmem[k][idx];
          if (we[k] && !oob) begin
            for (int b = 0; b < 4; b++) if (be[k][b]) mmem[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
            if (idx == 0 && be[k][0]) mdone[k] = wdata[k][0];
            if (idx == 1) mres[k] = mmem[k][1];
          end
          slot = (qh[k] + qn[k]) % 8;
          qd[k][slot] = word; qe[k][slot] = oob; qdue[k][slot] = cyc + LAT_T[k]; qn[k]++;
        end
        held[k] = (req[k] && !exp_gnt[k]) ? held[k] + 1 : 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic cycles(int n);
    repeat (n) begin sample(); advance(); end
  endtask

  // Hold one request on instance k until granted; lat = cycles waited.
  task automatic issue(int k, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d, output int lat);
    req[k] = 1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      sample();
      if (exp_gnt[k]) lat = i;
      advance();
    end
    req[k] = 0;
    if (lat < 0) begin n_checks++; n_fail++; $display("FAIL issue_timeout[%0d]: got no grant want grant within 40", k); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < N; k++) begin req[k] = 0; we[k] = 0; addr[k] = 0; be[k] = 0; wdata[k] = 0; end
    model_reset(); cyc = 0;
    #2 rst_n = 0;
    sample();
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({gnt[k], rvalid[k], rdata[k], err[k], done[k], result[k]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: got %b/%b/%h/%b/%b/%h want all 0", k, gnt[k], rvalid[k], rdata[k], err[k], done[k], result[k]);
      end
    end
    advance();
    rst_n = 1;
    cycles(2);
  endtask

  task automatic test_fill();
    int lat; logic [31:0] d;
    for (int k = 0; k < N; k++)
      for (int w = 0; w < NW; w++) begin
        d = $urandom;
        if (w == 0) d[0] = 1'b0;
        issue(k, 1, 32'(w * 4), 4'hf, d, lat);
      end
    cycles(8);
  endtask

  task automatic test_write_read();
    int lat;
    issue(0, 1, 32'h4, 4'hf, 32'h37, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL wr_gnt_lat: got %0d want 0", lat); end
    sample();
    n_checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin n_fail++; $display("FAIL wr_resp: got %b/%h want 1/0", rvalid[0], rdata[0]); end
    n_checks++; if (result[0] !== 32'h37) begin n_fail++; $display("FAIL result_mirror: got %h want 37", result[0]); end
    advance();
    issue(0, 0, 32'h4, 4'hf, 32'h0, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL rd_gnt_lat: got %0d want 0", lat); end
    sample();
    n_checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h37) begin n_fail++; $display("FAIL rd_data: got %b/%h want 1/37", rvalid[0], rdata[0]); end
    advance();
  endtask

  task automatic test_wait_states();
    int lat;
    issue(1, 0, 32'h8, 4'hf, 32'h0, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL gw3_lat: got %0d want 3", lat); end
    sample();
    n_checks++; if (rvalid[1] !== 1'b1 || rdata[1] !== mmem[1][2]) begin n_fail++; $display("FAIL gw3_resp: got %b/%h want 1/%h", rvalid[1], rdata[1], mmem[1][2]); end
    advance();
    cycles(2);
  endtask

  task automatic test_queue_full();
    int eg [4] = '{0, 1, 5, 6};
    int er [4] = '{4, 5, 9, 10};
    int gof [4]; int rof [4]; logic [31:0] rdv [4]; int ng, nr, mg;
    ng = 0; nr = 0; mg = 0;
    for (int j = 0; j < 4; j++) begin gof[j] = -1; rof[j] = -1; rdv[j] = 0; end
    req[2] = 1; we[2] = 0; be[2] = 4'hf; addr[2] = 32'd64;
    for (int i = 0; i < 16; i++) begin
      sample();
      if (gnt[2] === 1'b1 && ng < 4) begin gof[ng] = i; ng++; end
      if (rvalid[2] === 1'b1 && nr < 4) begin rof[nr] = i; rdv[nr] = rdata[2]; nr++; end
      advance();
      if (exp_gnt[2]) begin
        mg++; addr[2] = addr[2] + 4;
        if (mg == 4) req[2] = 0;
      end
    end
    req[2] = 0;
    for (int j = 0; j < 4; j++) begin
      n_checks += 3;
      if (gof[j] !== eg[j]) begin n_fail++; $display("FAIL qfull_gnt%0d: got %0d want %0d", j, gof[j], eg[j]); end
      if (rof[j] !== er[j]) begin n_fail++; $display("FAIL qfull_rvalid%0d: got %0d want %0d", j, rof[j], er[j]); end
      if (rdv[j] !== mmem[2][16+j]) begin n_fail++; $display("FAIL qfull_data%0d: got %h want %h", j, rdv[j], mmem[2][16+j]); end
    end
  endtask

  task automatic test_byte_enable();
    int lat;
    issue(0, 1, 32'h14, 4'hf, 32'h11223344, lat);
    issue(0, 1, 32'h14, 4'b0010, 32'hAABBCCDD, lat);
    issue(0, 0, 32'h14, 4'hf, 32'h0, lat);
    sample();
    n_checks++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h1122CC44) begin n_fail++; $display("FAIL byte_enable: got %b/%h want 1/1122cc44", rvalid[0], rdata[0]); end
    advance();
  endtask

  task automatic test_mailbox_reset();
    int lat; int nrv;
    issue(0, 1, 32'h0, 4'b0001, 32'h1, lat);
    sample();
    n_checks++; if (done[0] !== 1'b1) begin n_fail++; $display("FAIL done_set: got %b want 1", done[0]); end
    advance();
    issue(2, 0, 32'h40, 4'hf, 32'h0, lat);
    cycles(1);
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({gnt[k], rvalid[k], rdata[k], err[k], done[k], result[k]} !== '0) begin
        n_fail++; $display("FAIL midreset_outputs[%0d]: got %b/%b/%h/%b/%b/%h want all 0", k, gnt[k], rvalid[k], rdata[k], err[k], done[k], result[k]);
      end
    end
    cycles(1);
    rst_n = 1;
    nrv = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (rvalid[2] === 1'b1) nrv++;
      advance();
    end
    n_checks++; if (nrv !== 0) begin n_fail++; $display("FAIL stale_rvalid: got %0d want 0", nrv); end
    issue(0, 0, 32'h0, 4'hf, 32'h0, lat);
    sample();
    n_checks++; if (rdata[0][0] !== 1'b1) begin n_fail++; $display("FAIL write_kept: got %h want bit0=1", rdata[0]); end
    advance();
  endtask

  task automatic test_err();
    int lat; logic [31:0] ed; bit ee;
`ifdef CEVERO_RESP_ERR_EN
    ed = 32'h0; ee = 1'b1;
`else
    ed = mmem[0][0]; ee = 1'b0;
`endif
    issue(0, 0, 32'h400, 4'hf, 32'h0, lat);
    sample();
    n_checks++; if (rvalid[0] !== 1'b1 || err[0] !== ee || rdata[0] !== ed) begin
      n_fail++; $display("FAIL oob_read: got %b/%b/%h want 1/%b/%h", rvalid[0], err[0], rdata[0], ee, ed);
    end
    advance();
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        int r; int unsigned w;
        if (!req[k] || exp_gnt[k]) begin
          r = $urandom_range(0, 9);
          if (r == 0)      w = $urandom_range(0, 1);
          else if (r == 1) w = 32'h100 + $urandom_range(0, 255);
          else             w = $urandom_range(2, 255);
          req[k]   = ($urandom_range(0, 3) != 0);
          we[k]    = $urandom_range(0, 1);
          addr[k]  = (w << 2) | $urandom_range(0, 3);
          be[k]    = 4'($urandom);
          wdata[k] = $urandom;
        end
      end
      sample();
      advance();
    end
    for (int k = 0; k < N; k++) req[k] = 0;
    cycles(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_wait_states();
    test_queue_full();
    test_byte_enable();
    test_mailbox_reset();
    test_err();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
